// File: rtl/tap_controller_pkg.sv
// TAP state encodings and next-state table shared by the controller.
// Optional debug port on the top is enabled with TAP_STATE_OUT_EN.
package tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_t;

    function automatic logic in_ir_col(tap_state_t s);
        return s inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
    endfunction

    function automatic tap_state_t tap_next(tap_state_t s, logic tms);
        tap_state_t n;
        case (s)
            TLR:    n = tms ? TLR    : RTI;
            RTI:    n = tms ? SEL_DR : RTI;
            SEL_DR: n = tms ? SEL_IR : CAP_DR;
            CAP_DR: n = tms ? EX1_DR : SH_DR;
            SH_DR:  n = tms ? EX1_DR : SH_DR;
            EX1_DR: n = tms ? UPD_DR : PAU_DR;
            PAU_DR: n = tms ? EX2_DR : PAU_DR;
            EX2_DR: n = tms ? UPD_DR : SH_DR;
            UPD_DR: n = tms ? SEL_DR : RTI;
            SEL_IR: n = tms ? TLR    : CAP_IR;
            CAP_IR: n = tms ? EX1_IR : SH_IR;
            SH_IR:  n = tms ? EX1_IR : SH_IR;
            EX1_IR: n = tms ? UPD_IR : PAU_IR;
            PAU_IR: n = tms ? EX2_IR : PAU_IR;
            EX2_IR: n = tms ? UPD_IR : SH_IR;
            UPD_IR: n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP pin / scan-register strobe bundle between the pins and the controller.
interface tap_controller_if;
    logic tms;
    logic tl_reset;
    logic captureIR, shiftIR, updateIR;
    logic captureDR, shiftDR, updateDR;
    logic tck_ir, tck_dr;
    logic select;
    logic tdo_en;

    modport master (
        output tms,
        input  tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR,
               updateDR, tck_ir, tck_dr, select, tdo_en
    );
    modport slave (
        input  tms,
        output tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR,
               updateDR, tck_ir, tck_dr, select, tdo_en
    );
endinterface

// File: rtl/tap_controller_clock_gate.sv
// Glitch-free clock gate: enable latched while tck is low, ANDed with tck.
module tap_clock_gate (
    input  logic tck,
    input  logic rst_n,
    input  logic en,
    output logic gclk
);
    logic en_l;

    // reset term keeps the gated clock low even if trst drops while tck is high
    always_latch begin
        if (!rst_n)
            en_l <= 1'b0;
        else if (!tck)
            en_l <= en;
    end

    assign gclk = tck & en_l;
endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with IR/DR strobes and gated scan clocks.
// Define TAP_STATE_OUT_EN to expose the encoded present state on tap_state.
module tap_controller
    import tap_pkg::*;
(
    input  logic              tck,
    input  logic              trst,
    tap_controller_if.slave   bus
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0]        tap_state
`endif
);
    tap_state_t state_q, state_d;
    logic       en_ir, en_dr;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = tap_next(state_q, bus.tms);
        bus.captureIR = (state_q == CAP_IR);
        bus.shiftIR   = (state_q == SH_IR);
        bus.captureDR = (state_q == CAP_DR);
        bus.shiftDR   = (state_q == SH_DR);
        bus.select    = in_ir_col(state_q);
        en_ir         = (state_q == CAP_IR) || (state_q == SH_IR);
        en_dr         = (state_q == CAP_DR) || (state_q == SH_DR);
    end

    // falling-edge outputs settle half a cycle after the state they decode
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            bus.updateIR <= 1'b0;
            bus.updateDR <= 1'b0;
            bus.tl_reset <= 1'b0;
            bus.tdo_en   <= 1'b0;
        end else begin
            bus.updateIR <= (state_q == UPD_IR);
            bus.updateDR <= (state_q == UPD_DR);
            bus.tl_reset <= (state_q != TLR);
            bus.tdo_en   <= (state_q == SH_IR) || (state_q == SH_DR);
        end
    end

    tap_clock_gate u_gate_ir (.tck(tck), .rst_n(trst), .en(en_ir), .gclk(bus.tck_ir));
    tap_clock_gate u_gate_dr (.tck(tck), .rst_n(trst), .en(en_dr), .gclk(bus.tck_dr));

`ifdef TAP_STATE_OUT_EN
    assign tap_state = state_q;
`endif
endmodule
